// File: rtl/fifo_pkg.sv
// Shared defaults and encodings for the RAM-backed FIFO controller and its pointer sub-module.
package fifo_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   // Which side wins the single RAM port when push and pop collide.
   typedef enum logic {
      PRIO_POP  = 1'b0,
      PRIO_PUSH = 1'b1
   } prio_e;

   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_WR   = 2'd1,
      GNT_RD   = 2'd2
   } gnt_e;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// ADDR_W+1 bit FIFO pointer; the MSB is the wrap bit, the low bits address the RAM.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              ck,
   input  logic              rst_n,
   input  logic              i_inc,
   output logic [ADDR_W:0]   o_ptr
);

   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0] r_ptr;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + PTR_ONE;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Push/pop FIFO front end driving a single-port synchronous RAM, one access per cycle.
// Optional sticky overflow/underflow outputs are enabled with FIFO_RAM_CTRL_ERR_EN.
module fifo_ram_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              ck,
   input  logic              rst_n,
   input  logic              push_valid,
   input  logic [DATA_W-1:0] push_data,
   output logic              push_ready,
   input  logic              pop_req,
   output logic              pop_ready,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
`ifdef FIFO_RAM_CTRL_ERR_EN
   output logic              ovf,
   output logic              udf,
`endif
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int              DEPTH   = fifo_depth(ADDR_W);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W:0] w_wr_ptr;
   logic [ADDR_W:0] w_rd_ptr;
   logic [ADDR_W:0] w_count;
   logic            w_full;
   logic            w_empty;
   logic            w_want_w;
   logic            w_want_r;
   logic            w_gnt_w;
   logic            w_gnt_r;
   gnt_e            w_gnt;
   prio_e           r_prio;
   logic            r_pop_valid;

   fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
      .ck    (ck),
      .rst_n (rst_n),
      .i_inc (w_gnt_w),
      .o_ptr (w_wr_ptr)
   );

   fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
      .ck    (ck),
      .rst_n (rst_n),
      .i_inc (w_gnt_r),
      .o_ptr (w_rd_ptr)
   );

   // Wrap-bit pointers make the difference the exact occupancy, 0..DEPTH.
   assign w_count = w_wr_ptr - w_rd_ptr;
   assign w_full  = (w_count == DEPTH_C);
   assign w_empty = (w_count == '0);

   assign w_want_w = push_valid && !w_full;
   assign w_want_r = pop_req && !w_empty;

   always_comb begin
      w_gnt = GNT_IDLE;
      if (w_want_w && w_want_r) begin
         w_gnt = (r_prio == PRIO_PUSH) ? GNT_WR : GNT_RD;
      end else if (w_want_w) begin
         w_gnt = GNT_WR;
      end else if (w_want_r) begin
         w_gnt = GNT_RD;
      end
   end

   assign w_gnt_w = (w_gnt == GNT_WR);
   assign w_gnt_r = (w_gnt == GNT_RD);

   assign push_ready = !w_full  && !(w_want_r && w_gnt_r);
   assign pop_ready  = !w_empty && !(w_want_w && w_gnt_w);

   // Round-robin: the side that just won a contended cycle loses the next one.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= PRIO_POP;
      end else if (w_want_w && w_want_r) begin
         r_prio <= (r_prio == PRIO_POP) ? PRIO_PUSH : PRIO_POP;
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_pop_valid <= 1'b0;
      end else begin
         r_pop_valid <= w_gnt_r;
      end
   end

   always_comb begin
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = w_rd_ptr[ADDR_W-1:0];
      ram_wdata = '0;
      if (w_gnt_w) begin
         ram_cs    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = w_wr_ptr[ADDR_W-1:0];
         ram_wdata = push_data;
      end else if (w_gnt_r) begin
         ram_cs    = 1'b1;
      end
   end

`ifdef FIFO_RAM_CTRL_ERR_EN
   logic r_ovf;
   logic r_udf;

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (push_valid && w_full) begin
            r_ovf <= 1'b1;
         end
         if (pop_req && w_empty) begin
            r_udf <= 1'b1;
         end
      end
   end

   assign ovf = r_ovf;
   assign udf = r_udf;
`endif

   assign pop_valid = r_pop_valid;
   assign pop_data  = ram_rdata;
   assign full      = w_full;
   assign empty     = w_empty;
   assign count     = w_count;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Scoreboard bench for fifo_ram_ctrl with a behavioural RAM and a queue-based reference FIFO.
module tb_fifo_ram_ctrl;

   logic       ck = 1'b0;
   logic       rst_n = 1'b0;
   logic       push_valid = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       push_ready;
   logic       pop_req = 1'b0;
   logic       pop_ready;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       ram_cs;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata = 8'h00;
`ifdef FIFO_RAM_CTRL_ERR_EN
   logic       ovf;
   logic       udf;
`endif

   always #5 ck = ~ck;

   fifo_ram_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
      .ck         (ck),
      .rst_n      (rst_n),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .pop_req    (pop_req),
      .pop_ready  (pop_ready),
      .pop_data   (pop_data),
      .pop_valid  (pop_valid),
      .full       (full),
      .empty      (empty),
      .count      (count),
`ifdef FIFO_RAM_CTRL_ERR_EN
      .ovf        (ovf),
      .udf        (udf),
`endif
      .ram_cs     (ram_cs),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // Behavioural single-port RAM with registered read data.
   logic [7:0] mem [16];
   always @(posedge ck) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_cs && !ram_we) ram_rdata <= mem[ram_addr];
   end

   // Reference model state.
   bit [7:0] mq[$];
   bit [7:0] exp_q[$];
   int       m_wp = 0;
   int       m_rp = 0;
   bit       m_prio_push = 1'b0;
   bit       m_pv = 1'b0;
   bit       m_ovf = 1'b0;
   bit       m_udf = 1'b0;
   bit       chk_en = 1'b0;
   int       n_chk = 0;
   int       n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      m_wp = 0;
      m_rp = 0;
      m_prio_push = 1'b0;
      m_pv = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   // Per-cycle check of flags, readies and RAM drive against the queue model.
   always @(negedge ck) begin
      if (chk_en) begin
         int n;
         bit ww, wr, gw, gr;
         n  = mq.size();
         ww = push_valid && (n < 16);
         wr = pop_req && (n > 0);
         if (ww && wr) begin
            gw = m_prio_push;
            gr = !m_prio_push;
            m_prio_push = !m_prio_push;
         end else begin
            gw = ww;
            gr = wr;
         end
         chk("count", int'(count), n);
         chk("full", int'(full), int'(n == 16));
         chk("empty", int'(empty), int'(n == 0));
         chk("push_ready", int'(push_ready), int'((n < 16) && !gr));
         chk("pop_ready", int'(pop_ready), int'((n > 0) && !gw));
         chk("pop_valid", int'(pop_valid), int'(m_pv));
         chk("ram_cs", int'(ram_cs), int'(gw || gr));
         chk("ram_we", int'(ram_we), int'(gw));
         chk("ram_addr", int'(ram_addr), gw ? m_wp : m_rp);
         if (gw) chk("ram_wdata", int'(ram_wdata), int'(push_data));
         else if (!gr) chk("ram_wdata_idle", int'(ram_wdata), 0);
`ifdef FIFO_RAM_CTRL_ERR_EN
         chk("ovf", int'(ovf), int'(m_ovf));
         chk("udf", int'(udf), int'(m_udf));
         if (push_valid && n == 16) m_ovf = 1'b1;
         if (pop_req && n == 0) m_udf = 1'b1;
`endif
         if (gw) begin
            mq.push_back(push_data);
            m_wp = (m_wp + 1) % 16;
         end
         if (gr) begin
            exp_q.push_back(mq.pop_front());
            m_rp = (m_rp + 1) % 16;
         end
         m_pv = gr;
      end
   end

   // Monitor: every pop_valid consumes the oldest expected word.
   always @(negedge ck) begin
      if (chk_en && pop_valid) begin
         if (exp_q.size() == 0) begin
            chk("pop_valid_unexpected", 1, 0);
         end else begin
            bit [7:0] e;
            e = exp_q.pop_front();
            $display("pop  data=0x%02h expected=0x%02h", pop_data, e);
            chk("pop_data", int'(pop_data), int'(e));
         end
      end
   end

   task automatic step(input logic pv, input logic [7:0] pd, input logic pr);
      @(posedge ck);
      #1;
      push_valid = pv;
      push_data  = pd;
      pop_req    = pr;
   endtask

   initial begin
      #3;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_pop_valid", int'(pop_valid), 0);
      @(posedge ck);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Fill, then one push too many.
      for (int i = 0; i < 17; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      // Drain, then one pop too many.
      for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);

      // Wrap across the address space.
      for (int b = 0; b < 4; b++)
         for (int i = 0; i < 10; i++)
            if (b % 2 == 0) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            else step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

      // Contention with four words resident.
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

      // Random traffic with shifting push/pop bias.
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 150; i++) begin
            int pw;
            pw = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
            step(1'($urandom_range(0, 99) < pw), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 99) >= pw - 10));
         end
      end
      for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b1);

      // Reset asserted mid-cycle right after a pop accept.
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      @(posedge ck);
      #2;
      chk_en     = 1'b0;
      push_valid = 1'b0;
      pop_req    = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("async_pop_valid", int'(pop_valid), 0);
      chk("async_count", int'(count), 0);
      chk("async_empty", int'(empty), 1);
`ifdef FIFO_RAM_CTRL_ERR_EN
      chk("async_ovf", int'(ovf), 0);
      chk("async_udf", int'(udf), 0);
`endif
      model_reset();
      @(posedge ck);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      step(1'b1, 8'hCA, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
      @(negedge ck);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("final_empty", int'(empty), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_ram_ctrl.md
Name: fifo_ram_ctrl

Overview:
Initiator side of the single-port synchronous RAM interface (ck, chip select, write enable, 8-bit data in/out, 4-bit address). Turns a push/pop FIFO interface into RAM accesses, with one access per cycle. Maintains the read/write pointers, occupancy and flags. Sits between the FIFO user logic and the RAM instance in the FIFO top level.

Parameters:
DATA_W, 8, data width; must match the RAM word width.
ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W (local, 16 by default).

Ports:
ck  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
push_valid  in  1  write request.
push_data  in  DATA_W  write word.
push_ready  out  1  push accepted this cycle when push_valid && push_ready.
pop_req  in  1  read request.
pop_ready  out  1  pop accepted this cycle when pop_req && pop_ready.
pop_data  out  DATA_W  read word; meaningful only while pop_valid=1.
pop_valid  out  1  one-cycle pulse, cycle after pop accept.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  ADDR_W+1  occupancy, 0..DEPTH.
ram_cs  out  1  RAM chip select.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_wdata  out  DATA_W  RAM data in.
ram_rdata  in  DATA_W  RAM data out; registered, valid 1 cycle after a read.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, prio=POP, empty=1, full=0. RAM contents are untouched.
- Pointers are ADDR_W+1 bits, and the MSB is the wrap bit. The RAM address is ptr[ADDR_W-1:0]. Wrap 15->0 is by natural overflow.
- Arbitration, single port:
  - want_w = push_valid && !full; want_r = pop_req && !empty.
  - Only one of them: grant it.
  - Both: grant per prio. prio toggles after every contended cycle (round-robin), so neither side starves.
  - push_ready = !full && !(want_r && grant goes to read). pop_ready is the symmetric expression.
  - Ready signals are combinational from requests, flags and prio.
- RAM drive is combinational in the grant cycle; the RAM samples it on the next rising ck.
  - Write grant: ram_cs=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=push_data.
  - Read grant: ram_cs=1, ram_we=0, ram_addr=rd_ptr.
  - Idle: ram_cs=0, ram_we=0, ram_addr=rd_ptr, ram_wdata=0.
- Latency: pop_valid rises exactly 1 cycle after the pop-accept edge. pop_data = ram_rdata (pass-through).
- Pointer and count update on the accept edge: write gives wr_ptr+1, count+1; read gives rd_ptr+1, count-1. No cycle updates both.
- Read-after-write: a word pushed at edge N is poppable from cycle N+1 (empty drops at N).
- Boundaries:
  - push while full: not accepted, state unchanged.
  - pop while empty: not accepted, pop_valid stays 0.
  - full and empty are never both 1.
- Reset mid-read: the pending pop_valid is cleared and the data is lost. This is acceptable.

Optional Feature:
Macro FIFO_RAM_CTRL_ERR_EN.
- Defined: adds outputs ovf and udf, both sticky and 1 bit.
  - ovf sets on a cycle with push_valid && full.
  - udf sets on a cycle with pop_req && empty.
  - Cleared only by rst_n.
- Undefined: the ports and logic are absent; illegal requests are silently ignored as above.

Decomposition:
- Package fifo_pkg holds DATA_W/ADDR_W defaults, the DEPTH function and the PRIO_POP/PRIO_PUSH encodings.
- One sub-module is natural: fifo_ptr. It implements an ADDR_W+1-bit pointer with increment enable and async reset, and is instantiated twice.
- Arbitration, count and flags stay in the top.

Test Plan:
1. Reset then 16 pushes of 0xC0..0xCF, no pops. Each push is accepted with ram_cs=1, ram_we=1 and ram_addr 0..15. After the last push: full=1, count=16. A 17th push sees push_ready=0 and wr_ptr unchanged.
2. 16 pops after step 1. Each shows ram_cs=1, ram_we=0. pop_valid pulses 1 cycle after each accept with pop_data 0xC0..0xCF in order. Then empty=1; a further pop_req gives pop_ready=0 and no pop_valid.
3. Wrap: push 10, pop 10, push 10. ram_addr wraps 15->0 at push #7 of the second burst. Popping the 10 returns the second-burst data in order; count tracks 10/0/10.
4. Contention: count=4, push_valid and pop_req held high for 6 cycles. Grants alternate pop,push,pop,push,pop,push. count ends at 4 and no cycle has two RAM accesses.
5. Reset mid-operation: assert rst_n=0 asynchronously between clock edges, the cycle after a pop accept. pop_valid=0, count=0 and empty=1 take effect immediately, not at the next edge. After release, a push of 0xCA then a pop returns 0xCA.
6. With FIFO_RAM_CTRL_ERR_EN: push while full sets ovf=1; pop while empty sets udf=1. Both hold through normal traffic and clear only on rst_n.
